// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and helpers for the audio frame packer.
//   pair_state_e    : left/right pairing state (WAIT_L, HAVE_L)
//   RESYNC_MAX      : saturation value of the pairing-error counter
//   chan_to_sample  : pulls the signed, left-justified sample out of a
//                     channel word and returns it sign-extended to 64 bits
// -----------------------------------------------------------------------------
package audio_pkg;

    typedef enum logic [0:0] {
        WAIT_L = 1'b0,
        HAVE_L = 1'b1
    } pair_state_e;

    localparam int unsigned RESYNC_MAX = 32'd255;

    // Widest channel word the helper can handle.
    localparam int unsigned WORD_MAX_W = 32'd64;

    // The sample occupies the top sample_w bits of a data_w-bit word. Shift it
    // up to bit 63 and then shift arithmetically back down so the caller gets
    // a sign-extended value it can slice to whatever width it needs.
    function automatic logic [63:0] chan_to_sample(
        input logic [63:0] word,
        input int unsigned data_w,
        input int unsigned sample_w
    );
        logic [63:0] aligned;
        aligned = word << (WORD_MAX_W - data_w);
        return 64'($signed(aligned) >>> (WORD_MAX_W - sample_w));
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo
// Single-clock show-ahead FIFO: the head entry is always visible on rd_data_o
// while empty_o is low. A write into a full FIFO is accepted only when a read
// happens in the same cycle.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (clears storage and pointers)
//   wr_en_i    : write request
//   wr_data_i  : write data
//   rd_en_i    : pop the head entry (ignored when empty)
//   rd_data_o  : head entry
//   full_o     : FIFO holds DEPTH entries
//   empty_o    : FIFO holds no entries
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             wr_fire_s;
    logic             rd_fire_s;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign rd_fire_s = rd_en_i & ~empty_o;
    assign wr_fire_s = wr_en_i & (~full_o | rd_fire_s);
    assign rd_data_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_fire_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_fire_s, rd_fire_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_fire_s) begin
                mem_q[wr_ptr_q] <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/audio_frame_packer.sv
// -----------------------------------------------------------------------------
// audio_frame_packer
// Pairs left/right channel words from the I2S receiver stream, mixes each pair
// to a signed mono sample, buffers the samples and emits fixed-length frames.
//   AXIS_ACLK / AXIS_ARESET : clock, synchronous active-high reset
//   S_AXIS_*                : channel words in (TLAST=1 marks the right word)
//   M_AXIS_*                : mono samples out, TLAST on the last of a frame
//   overflow                : sticky, a mono sample was dropped (FIFO full)
//   resync_count            : saturating count of pairing errors
// Optional (macro PEAK_DETECT_EN):
//   frame_peak / frame_peak_valid : max |mono| of the frame just completed
// -----------------------------------------------------------------------------
module audio_frame_packer
    import audio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter int unsigned FRAME_LEN    = 256,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                    AXIS_ACLK,
    input  logic                    AXIS_ARESET,
    input  logic                    S_AXIS_TVALID,
    output logic                    S_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                    S_AXIS_TLAST,
    output logic                    M_AXIS_TVALID,
    input  logic                    M_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic                    M_AXIS_TLAST,
    output logic                    overflow,
    output logic [7:0]              resync_count
`ifdef PEAK_DETECT_EN
    ,
    output logic [SAMPLE_WIDTH-1:0] frame_peak,
    output logic                    frame_peak_valid
`endif
);

    localparam int unsigned SW       = SAMPLE_WIDTH;
    localparam int unsigned EXT_W    = DATA_WIDTH - SAMPLE_WIDTH;
    localparam int unsigned FCNT_W   = $clog2(FRAME_LEN);
    localparam logic [FCNT_W-1:0] LAST_CNT = FCNT_W'(FRAME_LEN - 32'd1);

    // ---------------- pairing ----------------
    pair_state_e   state_q;
    pair_state_e   state_d;
    logic [SW-1:0] left_q;
    logic [SW-1:0] left_d;
    logic [SW-1:0] right_q;
    logic [SW-1:0] right_d;
    logic          pair_valid_q;
    logic          pair_valid_d;
    logic [7:0]    resync_q;
    logic [7:0]    resync_d;
    logic [7:0]    resync_inc_s;
    logic          in_fire_s;
    logic [63:0]   sample_full_s;
    logic [SW-1:0] in_sample_s;
    logic          unused_sample_bits_s;

    // The input is never back-pressured; ready simply follows reset.
    assign S_AXIS_TREADY = ~AXIS_ARESET;
    assign in_fire_s     = S_AXIS_TVALID & S_AXIS_TREADY;

    assign sample_full_s        = chan_to_sample(64'(S_AXIS_TDATA), DATA_WIDTH, SAMPLE_WIDTH);
    assign in_sample_s          = sample_full_s[SW-1:0];
    assign unused_sample_bits_s = ^sample_full_s[63:SW];
    assign resync_inc_s         = (resync_q == 8'(RESYNC_MAX)) ? resync_q : resync_q + 8'd1;

    // Pairing FSM next-state: store lefts, launch a mix on a right that
    // follows a left, count orphan rights and duplicate lefts.
    always_comb begin
        state_d      = state_q;
        left_d       = left_q;
        right_d      = right_q;
        pair_valid_d = 1'b0;
        resync_d     = resync_q;
        if (in_fire_s) begin
            case (state_q)
                WAIT_L: begin
                    if (!S_AXIS_TLAST) begin
                        left_d  = in_sample_s;
                        state_d = HAVE_L;
                    end else begin
                        resync_d = resync_inc_s;
                        state_d  = WAIT_L;
                    end
                end
                HAVE_L: begin
                    if (!S_AXIS_TLAST) begin
                        left_d   = in_sample_s;
                        resync_d = resync_inc_s;
                        state_d  = HAVE_L;
                    end else begin
                        right_d      = in_sample_s;
                        pair_valid_d = 1'b1;
                        state_d      = WAIT_L;
                    end
                end
                default: begin
                    state_d = WAIT_L;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Pairing state registers.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q      <= WAIT_L;
            left_q       <= '0;
            right_q      <= '0;
            pair_valid_q <= 1'b0;
            resync_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            left_q       <= left_d;
            right_q      <= right_d;
            pair_valid_q <= pair_valid_d;
            resync_q     <= resync_d;
        end
    end

    assign resync_count = resync_q;

    // ---------------- mix ----------------
    // One extra bit holds the full sum; dropping bit 0 is the arithmetic
    // shift right by one, and the result always fits back in SW bits.
    logic [SW:0]   sum_s;
    logic [SW-1:0] mono_q;
    logic          mono_valid_q;

    assign sum_s = {left_q[SW-1], left_q} + {right_q[SW-1], right_q};

    // Mix register stage.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            mono_q       <= '0;
            mono_valid_q <= 1'b0;
        end else begin
            mono_q       <= sum_s[SW:1];
            mono_valid_q <= pair_valid_q;
        end
    end

    // ---------------- framing + FIFO ----------------
    logic [FCNT_W-1:0]   frame_cnt_q;
    logic [FCNT_W-1:0]   frame_cnt_d;
    logic                overflow_q;
    logic                overflow_d;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                fifo_rd_s;
    logic                fifo_wr_s;
    logic                drop_s;
    logic                frame_last_s;
    logic [DATA_WIDTH:0] fifo_wdata_s;
    logic [DATA_WIDTH:0] fifo_rdata_s;

    assign fifo_rd_s    = M_AXIS_TREADY & ~fifo_empty_s;
    // A full FIFO still takes the write when the head leaves in the same cycle.
    assign fifo_wr_s    = mono_valid_q & (~fifo_full_s | fifo_rd_s);
    assign drop_s       = mono_valid_q & fifo_full_s & ~fifo_rd_s;
    assign frame_last_s = (frame_cnt_q == LAST_CNT);
    assign fifo_wdata_s = {frame_last_s, {EXT_W{mono_q[SW-1]}}, mono_q};

    // Frame position and overflow next-state; dropped samples leave the
    // frame position untouched so frames stay exactly FRAME_LEN long.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q | drop_s;
        if (fifo_wr_s) begin
            if (frame_last_s) begin
                frame_cnt_d = '0;
            end else begin
                frame_cnt_d = frame_cnt_q + FCNT_W'(1);
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame position and overflow registers.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    axis_sync_fifo #(
        .WIDTH (DATA_WIDTH + 32'd1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (AXIS_ACLK),
        .rst_i     (AXIS_ARESET),
        .wr_en_i   (fifo_wr_s),
        .wr_data_i (fifo_wdata_s),
        .rd_en_i   (fifo_rd_s),
        .rd_data_o (fifo_rdata_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    assign M_AXIS_TVALID = ~fifo_empty_s;
    assign M_AXIS_TDATA  = fifo_rdata_s[DATA_WIDTH-1:0];
    assign M_AXIS_TLAST  = fifo_rdata_s[DATA_WIDTH];
    assign overflow      = overflow_q;

`ifdef PEAK_DETECT_EN
    // ---------------- peak detect ----------------
    localparam logic [SW-1:0] SMIN = {1'b1, {(SW-1){1'b0}}};
    localparam logic [SW-1:0] SMAX = {1'b0, {(SW-1){1'b1}}};

    logic [SW-1:0] abs_s;
    logic [SW-1:0] peak_max_s;
    logic [SW-1:0] peak_acc_q;
    logic [SW-1:0] peak_acc_d;
    logic [SW-1:0] frame_peak_q;
    logic [SW-1:0] frame_peak_d;
    logic          frame_peak_valid_q;
    logic          frame_peak_valid_d;

    // |mono| with the most negative value saturated to the positive maximum.
    always_comb begin
        abs_s = mono_q;
        if (mono_q == SMIN) begin
            abs_s = SMAX;
        end else if (mono_q[SW-1]) begin
            abs_s = (~mono_q) + SW'(1);
        end else begin
            abs_s = mono_q;
        end
        peak_max_s = (abs_s > peak_acc_q) ? abs_s : peak_acc_q;
    end

    // Peak accumulate/publish next-state, driven by accepted FIFO writes.
    always_comb begin
        peak_acc_d         = peak_acc_q;
        frame_peak_d       = frame_peak_q;
        frame_peak_valid_d = 1'b0;
        if (fifo_wr_s) begin
            if (frame_last_s) begin
                frame_peak_d       = peak_max_s;
                frame_peak_valid_d = 1'b1;
                peak_acc_d         = '0;
            end else begin
                peak_acc_d = peak_max_s;
            end
        end else begin
            peak_acc_d = peak_acc_q;
        end
    end

    // Peak registers.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            peak_acc_q         <= '0;
            frame_peak_q       <= '0;
            frame_peak_valid_q <= 1'b0;
        end else begin
            peak_acc_q         <= peak_acc_d;
            frame_peak_q       <= frame_peak_d;
            frame_peak_valid_q <= frame_peak_valid_d;
        end
    end

    assign frame_peak       = frame_peak_q;
    assign frame_peak_valid = frame_peak_valid_q;
`endif

endmodule

// File: tb/tb_audio_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_audio_frame_packer
// Self-checking bench for audio_frame_packer (SAMPLE_WIDTH=24, FRAME_LEN=4,
// FIFO_DEPTH=4). A behavioural model turns every driven beat into expected
// output samples (pairing, averaging, frame position, drops) in a queue.
// Peak-detect checks are compiled in with PEAK_DETECT_EN.
// -----------------------------------------------------------------------------
module tb_audio_frame_packer;

    localparam int DW = 32;
    localparam int SW = 24;
    localparam int FL = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          ovf;
    logic [7:0]    resync;
`ifdef PEAK_DETECT_EN
    logic [SW-1:0] peak;
    logic          peak_v;
`endif

    always #5 clk = ~clk;

    audio_frame_packer #(
        .DATA_WIDTH   (DW),
        .SAMPLE_WIDTH (SW),
        .FRAME_LEN    (FL),
        .FIFO_DEPTH   (FD)
    ) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .S_AXIS_TVALID (s_valid),
        .S_AXIS_TREADY (s_ready),
        .S_AXIS_TDATA  (s_data),
        .S_AXIS_TLAST  (s_last),
        .M_AXIS_TVALID (m_valid),
        .M_AXIS_TREADY (m_ready),
        .M_AXIS_TDATA  (m_data),
        .M_AXIS_TLAST  (m_last),
        .overflow      (ovf),
        .resync_count  (resync)
`ifdef PEAK_DETECT_EN
        ,
        .frame_peak       (peak),
        .frame_peak_valid (peak_v)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int n_last  = 0;

    // Behavioural model state.
    logic [32:0] exp_q[$];
    bit          m_have;
    int          m_left;
    int          m_resync;
    int          m_fpos;
    bit          m_stall;
    bit          m_ovf;
    int          m_emitted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        m_have    = 1'b0;
        m_left    = 0;
        m_resync  = 0;
        m_fpos    = 0;
        m_ovf     = 1'b0;
        m_emitted = 0;
    endfunction

    // Sample = signed top 24 bits; mono = floor((L+R)/2); a sample is lost
    // when the downstream is stalled and FD samples are already waiting.
    function automatic void model_beat(input logic [31:0] d, input bit last);
        int s;
        int mono;
        s = int'($signed(d[31:8]));
        if (!last) begin
            if (m_have) m_resync = (m_resync < 255) ? m_resync + 1 : 255;
            m_left = s;
            m_have = 1'b1;
        end else if (!m_have) begin
            m_resync = (m_resync < 255) ? m_resync + 1 : 255;
        end else begin
            m_have = 1'b0;
            mono   = (m_left + s) >>> 1;
            if (m_stall && exp_q.size() >= FD) begin
                m_ovf = 1'b1;
            end else begin
                exp_q.push_back({(m_fpos == FL - 1), 32'(mono)});
                m_fpos = (m_fpos + 1) % FL;
                m_emitted++;
            end
        end
    endfunction

    // One clock: score any handshake seen before the edge, then step past it.
    task automatic clk_step();
        logic [32:0] e;
        @(negedge clk);
        if (!rst && m_valid && m_ready) begin
            n_out++;
            if (m_last) n_last++;
            if (exp_q.size() == 0) begin
                check("spurious_sample", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sample_data", m_data, e[31:0]);
                check("sample_last", 32'(m_last), 32'(e[32]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        model_beat(d, last);
        clk_step();
        s_valid = 1'b0;
        s_data  = 32'd0;
        s_last  = 1'b0;
    endtask

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input int gap);
        send_beat(l, 1'b0);
        repeat (gap) clk_step();
        send_beat(r, 1'b1);
        clk_step();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) clk_step();
        repeat (4) clk_step();
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_data"},  m_data,       32'd0);
        check({tag, "_m_last"},  32'(m_last),  32'd0);
        check({tag, "_ovf"},     32'(ovf),     32'd0);
        check({tag, "_resync"},  32'(resync),  32'd0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        repeat (2) clk_step();
        model_reset();
        rst = 1'b0;
        clk_step();
        n_out  = 0;
        n_last = 0;
    endtask

    initial begin
        logic [31:0] hold;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'd0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        m_stall = 1'b0;
        model_reset();

        // Reset state.
        repeat (3) clk_step();
        check_reset_vals("rst0");
        rst = 1'b0;
        clk_step();
        check("ready_after_rst", 32'(s_ready), 32'd1);

        // Full-scale mix and latency after the right beat.
        do_reset();
        m_ready = 1'b0;
        send_beat(32'h7FFFFF00, 1'b0);
        send_beat(32'h7FFFFF00, 1'b1);
        check("lat_edge_t", 32'(m_valid), 32'd0);
        clk_step();
        check("lat_edge_t1", 32'(m_valid), 32'd0);
        clk_step();
        check("lat_edge_t2", 32'(m_valid), 32'd1);
        check("fullscale_pos", m_data, 32'h007FFFFF);
        m_ready = 1'b1;
        drain();
        m_ready = 1'b0;
        send_pair(32'h80000000, 32'h7FFFFF00, 1);
        repeat (2) clk_step();
        check("min_plus_max", m_data, 32'hFFFFFFFF);
        m_ready = 1'b1;
        drain();

        // Eight random pairs, free-flowing output.
        do_reset();
        for (int p = 0; p < 8; p++) send_pair($urandom, $urandom, int'($urandom_range(0, 2)));
        drain();
        check("stream_count", 32'(n_out), 32'd8);
        check("stream_lasts", 32'(n_last), 32'd2);
        check("stream_resync", 32'(resync), 32'd0);

        // Orphan right, duplicate left, then a proper right.
        do_reset();
        m_ready = 1'b0;
        send_beat(32'h00000300, 1'b1);
        send_beat(32'h00000100, 1'b0);
        send_beat(32'h00000200, 1'b0);
        send_beat(32'h00000200, 1'b1);
        repeat (3) clk_step();
        check("resync_two", 32'(resync), 32'd2);
        check("resync_model", 32'(resync), 32'(m_resync));
        check("resync_sample", m_data, 32'h00000002);
        m_ready = 1'b1;
        drain();
        check("resync_count_out", 32'(n_out), 32'd1);

        // Stall: four held, fifth and sixth dropped, then release.
        do_reset();
        m_ready = 1'b0;
        m_stall = 1'b1;
        hold    = 32'd0;
        for (int p = 1; p <= 6; p++) begin
            send_pair($urandom, $urandom, 0);
            repeat (2) clk_step();
            if (p == 4) check("ovf_after_4", 32'(ovf), 32'd0);
            if (p == 5) begin
                check("ovf_after_5", 32'(ovf), 32'd1);
                hold = m_data;
            end
        end
        check("stall_hold_data", m_data, hold);
        check("stall_valid", 32'(m_valid), 32'd1);
        m_stall = 1'b0;
        m_ready = 1'b1;
        drain();
        check("stall_count", 32'(n_out), 32'd4);
        check("stall_lasts", 32'(n_last), 32'd1);
        check("ovf_sticky", 32'(ovf), 32'(m_ovf));

        // Reset in the middle of a frame with a sample in flight.
        do_reset();
        send_pair($urandom, $urandom, 0);
        send_pair($urandom, $urandom, 1);
        drain();
        send_beat($urandom, 1'b0);
        send_beat($urandom, 1'b1);
        rst = 1'b1;
        repeat (2) clk_step();
        check_reset_vals("rst_mid");
        model_reset();
        rst = 1'b0;
        clk_step();
        n_out  = 0;
        n_last = 0;
        for (int p = 0; p < 4; p++) send_pair($urandom, $urandom, 1);
        drain();
        check("post_rst_count", 32'(n_out), 32'd4);
        check("post_rst_lasts", 32'(n_last), 32'd1);

        // Random beat stream with orphans and duplicates.
        do_reset();
        for (int b = 0; b < 40; b++) begin
            send_beat($urandom, bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 1)) clk_step();
        end
        drain();
        check("rand_resync", 32'(resync), 32'(m_resync));
        check("rand_count", 32'(n_out), 32'(m_emitted));

`ifdef PEAK_DETECT_EN
        // Peak over monos {5, -9, 3, 0}, then a frame holding the minimum.
        do_reset();
        send_pair(32'h00000500, 32'h00000500, 0);
        send_pair(32'hFFFFF700, 32'hFFFFF700, 0);
        send_pair(32'h00000300, 32'h00000300, 0);
        send_pair(32'h00000000, 32'h00000000, 0);
        for (int i = 0; i < 10 && !peak_v; i++) clk_step();
        check("peak_pulse", 32'(peak_v), 32'd1);
        check("peak_nine", 32'(peak), 32'd9);
        clk_step();
        check("peak_pulse_one", 32'(peak_v), 32'd0);
        send_pair(32'h80000000, 32'h80000000, 0);
        for (int p = 0; p < 3; p++) send_pair(32'h00000100, 32'h00000100, 0);
        for (int i = 0; i < 10 && !peak_v; i++) clk_step();
        check("peak_min_pulse", 32'(peak_v), 32'd1);
        check("peak_min_sat", 32'(peak), 32'h007FFFFF);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
